fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core.
//  Holds the PC, requests instructions from the instruction cache, and absorbs cache-miss waits.
//  Applies stall/flush/redirect from the hazard unit and EX stage.
//  Presents instr_d/pc_d to the decode stage, where instr_d feeds control_unit directly.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  PC value loaded on reset
//  NOP_INSTR   32'h0000_0013  bubble encoding (addi x0,x0,0); decodes as harmless I-type
// PORTS
//  clk              in   1   core clock; all state updates on posedge
//  rst_n            in   1   synchronous, active-low reset
//  stall_f          in   1   hazard unit: hold PC and IF/ID contents
//  flush_d          in   1   hazard unit: load bubble into IF/ID
//  redirect_valid   in   1   EX: taken branch / JAL / JALR resolved this cycle
//  redirect_target  in   32  EX: next PC; bits [1:0] are ignored and forced to 0
//  imem_addr        out  32  fetch address (equals pc_f)
//  imem_req         out  1   fetch request; 0 in reset, 1 otherwise
//  imem_rdata       in   32  instruction word, valid when imem_ready=1
//  imem_ready       in   1   cache hit/fill complete this cycle
//  instr_d          out  32  IF/ID instruction to decode / control_unit
//  pc_d             out  32  IF/ID PC of instr_d
//  pc_plus4_d       out  32  IF/ID pc_d+4 (JAL/JALR link value)
//  valid_d          out  1   1 = instr_d is a real instruction; 0 = bubble
//  miss_cycles      out  32  count of cycles with imem_req=1 and imem_ready=0; saturates at 2^32-1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - pc_f <= RESET_PC, instr_d <= NOP_INSTR, pc_d <= 0, pc_plus4_d <= 4, valid_d <= 0, miss_cycles <= 0.
//   - imem_req=0 while rst_n=0.
//   - Reset mid-miss abandons the fetch; the first request after reset is to RESET_PC.
//  PC update, priority high to low:
//   1. redirect_valid         -> pc_f <= {redirect_target[31:2],2'b00}. Wins over stall_f and miss.
//   2. stall_f                -> pc_f holds.
//   3. imem_ready=0 (miss)    -> pc_f holds; same address is re-requested next cycle.
//   4. otherwise              -> pc_f <= pc_f+4. 32-bit wrap: 32'hFFFF_FFFC+4 = 0.
//  IF/ID update, priority high to low:
//   1. flush_d or redirect_valid  -> bubble: instr_d=NOP_INSTR, valid_d=0, pc_d/pc_plus4_d don't-care (hold).
//   2. stall_f                    -> all IF/ID fields hold, including valid_d.
//   3. imem_ready=0               -> bubble (miss does not block older instrs downstream).
//   4. otherwise                  -> instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
//  Timing:
//   - Latency: a hit at pc_f in cycle N appears on instr_d in cycle N+1.
//   - Redirect in N: target requested in N+1, instruction on instr_d in N+2.
//  Simultaneous events:
//   - stall_f together with a miss: PC holds; IF/ID holds (stall wins over miss bubble).
//   - flush_d with stall_f: flush wins for IF/ID; stall still holds PC.
//  Miss FSM: FETCH <-> WAIT.
//   - FETCH: imem_ready=0 -> WAIT.
//   - WAIT: imem_ready=1 -> FETCH, and the line is accepted that cycle.
//   - WAIT: redirect -> FETCH at the new target; the stale fill is discarded.
//   - State is visible only through miss_cycles and pc hold; no extra output.
//   - miss_cycles increments in every cycle with imem_req=1 && imem_ready=0.
// STRUCTURE
//  riscv_pkg:
//   - constants: RESET_PC, NOP_INSTR.
//   - typedef struct packed {instr, pc, pc_plus4, valid} if_id_t.
//   - typedef enum logic {FETCH, WAIT} fetch_state_t.
//  Sub-module pc_next_sel (combinational next-PC priority mux); the PC and IF/ID flops live in fetch_stage.
// TESTING
//  - Reset + straight line: rst_n low 2 cycles, imem_ready=1 -> imem_addr BFC00000, BFC00004, BFC00008.
//    instr_d lags imem_addr by 1 cycle; valid_d first 1 at cycle 1 after release.
//  - Miss: imem_ready=0 for 3 cycles at BFC00008 -> addr holds 3 cycles; 3 bubbles (valid_d=0); miss_cycles=3.
//    Then the instruction at BFC00008 is delivered.
//  - Redirect: redirect_valid with target BFC00103 at pc_f=BFC00010 -> next imem_addr BFC00100.
//    instr_d=00000013 with valid_d=0 for 1 cycle.
//  - Stall: stall_f high 2 cycles -> imem_addr and instr_d/pc_d/valid_d unchanged for both cycles.
//  - Priority: redirect_valid+stall_f+imem_ready=0 in one cycle -> PC=target and IF/ID bubble.
//    Also flush_d+stall_f -> bubble while PC holds.
//  - Wrap and mid-miss reset: PC FFFFFFFC hit -> next addr 00000000.
//    rst_n low during WAIT -> addr BFC00000, miss_cycles=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I pipeline front end.
package riscv_pkg;

  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch PC: redirect beats stall, stall/miss hold, otherwise sequential.
module pc_next_sel (
  input  logic [31:0] pc_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        stall_i,
  input  logic        ready_i,
  output logic [31:0] pc_next_o
);

  always_comb begin
    pc_next_o = pc_i + 32'd4;
    if (redirect_valid_i)
      pc_next_o = {redirect_target_i[31:2], 2'b00};
    else if (stall_i || !ready_i)
      pc_next_o = pc_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, cache-miss wait tracking and redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] miss_cycles
);
  import riscv_pkg::*;

  logic [31:0]  pc_f_q, pc_f_d;
  if_id_t       ifid_q, ifid_d;
  fetch_state_t state_q, state_d;
  logic [31:0]  miss_q, miss_d;

  pc_next_sel u_pc_next_sel (
    .pc_i              (pc_f_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .stall_i           (stall_f),
    .ready_i           (imem_ready),
    .pc_next_o         (pc_f_d)
  );

  // Bubbles leave pc/pc_plus4 untouched; only instr and valid matter downstream.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_d || redirect_valid) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else if (stall_f) begin
      ifid_d = ifid_q;
    end else if (!imem_ready) begin
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else begin
      ifid_d.instr    = imem_rdata;
      ifid_d.pc       = pc_f_q;
      ifid_d.pc_plus4 = pc_f_q + 32'd4;
      ifid_d.valid    = 1'b1;
    end
  end

  // A redirect always returns to FETCH so a late fill for the old PC is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (!imem_ready && !redirect_valid) state_d = WAIT;
      WAIT:    if (imem_ready || redirect_valid)   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    miss_d = miss_q;
    if (imem_req && !imem_ready && (miss_q != 32'hFFFF_FFFF))
      miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f_q          <= RESET_PC;
      ifid_q.instr    <= NOP_INSTR;
      ifid_q.pc       <= 32'd0;
      ifid_q.pc_plus4 <= 32'd4;
      ifid_q.valid    <= 1'b0;
      state_q         <= FETCH;
      miss_q          <= 32'd0;
    end else begin
      pc_f_q  <= pc_f_d;
      ifid_q  <= ifid_d;
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  assign imem_req    = rst_n;
  assign imem_addr   = pc_f_q;
  assign instr_d     = ifid_q.instr;
  assign pc_d        = ifid_q.pc;
  assign pc_plus4_d  = ifid_q.pc_plus4;
  assign valid_d     = ifid_q.valid;
  assign miss_cycles = miss_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test of fetch_stage against an in-bench reference model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall_f, flush_d, redirect_valid, imem_ready;
  logic [31:0] redirect_target, imem_addr, imem_rdata;
  logic        imem_req, valid_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d, miss_cycles;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .miss_cycles(miss_cycles)
  );

  always #5 clk = ~clk;

  // Memory image: each word is a distinct function of its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  // Reference model
  logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_miss;
  logic        m_vd;
  bit          started = 0;

  always @(posedge clk) begin
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_p4 = 4; m_vd = 0; m_miss = 0;
      started = 1;
    end else begin
      if (!imem_ready && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
      if (flush_d || redirect_valid || (!stall_f && !imem_ready)) begin
        m_instr = NOP; m_vd = 0;
      end else if (!stall_f) begin
        m_instr = mem(old_pc); m_pcd = old_pc; m_p4 = old_pc + 4; m_vd = 1;
      end
      if (redirect_valid)                m_pc = redirect_target & 32'hFFFF_FFFC;
      else if (!stall_f && imem_ready)   m_pc = old_pc + 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model.imem_addr",   imem_addr,   m_pc);
      chk("model.imem_req",    {31'd0, imem_req}, {31'd0, rst_n});
      chk("model.instr_d",     instr_d,     m_instr);
      chk("model.valid_d",     {31'd0, valid_d}, {31'd0, m_vd});
      chk("model.pc_d",        pc_d,        m_pcd);
      chk("model.pc_plus4_d",  pc_plus4_d,  m_p4);
      chk("model.miss_cycles", miss_cycles, m_miss);
    end
  end

  task automatic step(input logic r, input logic st, input logic fl,
                      input logic rv, input logic [31:0] tgt, input logic rdy);
    rst_n = r; stall_f = st; flush_d = fl; redirect_valid = rv;
    redirect_target = tgt; imem_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] s_addr, s_instr, s_pcd, s_miss;
    logic        s_vd;
    rst_n = 0; stall_f = 0; flush_d = 0; redirect_valid = 0;
    redirect_target = 0; imem_ready = 1;

    // Reset, then straight-line fetch
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst.addr",  imem_addr, RST_PC);
    chk("rst.req",   {31'd0, imem_req}, 32'd0);
    chk("rst.instr", instr_d, NOP);
    chk("rst.pc4",   pc_plus4_d, 32'd4);
    chk("rst.miss",  miss_cycles, 32'd0);
    rst_n = 1; #1;
    chk("run.req",   {31'd0, imem_req}, 32'd1);
    step(1, 0, 0, 0, 0, 1);
    chk("run.addr1", imem_addr, 32'hBFC0_0004);
    chk("run.vd1",   {31'd0, valid_d}, 32'd1);
    chk("run.pcd1",  pc_d, 32'hBFC0_0000);
    step(1, 0, 0, 0, 0, 1);
    chk("run.addr2", imem_addr, 32'hBFC0_0008);

    // Three-cycle miss at BFC00008
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("miss.addr", imem_addr, 32'hBFC0_0008);
      chk("miss.vd",   {31'd0, valid_d}, 32'd0);
    end
    chk("miss.count", miss_cycles, 32'd3);
    step(1, 0, 0, 0, 0, 1);
    chk("miss.instr", instr_d, mem(32'hBFC0_0008));
    chk("miss.pcd",   pc_d, 32'hBFC0_0008);
    step(1, 0, 0, 0, 0, 1);
    chk("pre_redir.addr", imem_addr, 32'hBFC0_0010);

    // Redirect with misaligned target
    step(1, 0, 0, 1, 32'hBFC0_0103, 1);
    chk("redir.addr",  imem_addr, 32'hBFC0_0100);
    chk("redir.instr", instr_d, NOP);
    chk("redir.vd",    {31'd0, valid_d}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("redir.tgt_instr", instr_d, mem(32'hBFC0_0100));
    chk("redir.tgt_vd",    {31'd0, valid_d}, 32'd1);

    // Two-cycle stall
    s_addr = imem_addr; s_instr = instr_d; s_pcd = pc_d; s_vd = valid_d;
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 0, 1);
      chk("stall.addr",  imem_addr, s_addr);
      chk("stall.instr", instr_d, s_instr);
      chk("stall.pcd",   pc_d, s_pcd);
      chk("stall.vd",    {31'd0, valid_d}, {31'd0, s_vd});
    end
    step(1, 0, 0, 0, 0, 1);

    // Redirect beats stall and miss; flush beats stall for IF/ID
    s_miss = miss_cycles;
    step(1, 1, 0, 1, 32'h0000_1000, 0);
    chk("prio.addr", imem_addr, 32'h0000_1000);
    chk("prio.vd",   {31'd0, valid_d}, 32'd0);
    chk("prio.miss", miss_cycles, s_miss + 32'd1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    chk("flush.addr",  imem_addr, 32'h0000_1004);
    chk("flush.instr", instr_d, NOP);
    chk("flush.vd",    {31'd0, valid_d}, 32'd0);
    step(1, 0, 0, 0, 0, 1);

    // Wrap at top of address space
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 1);
    chk("wrap.addr1", imem_addr, 32'h0000_0000);
    chk("wrap.pcd",   pc_d, 32'hFFFF_FFFC);
    chk("wrap.pc4",   pc_plus4_d, 32'h0000_0000);

    // Reset during a miss wait
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("mrst.addr", imem_addr, RST_PC);
    chk("mrst.miss", miss_cycles, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("mrst.pcd",  pc_d, RST_PC);
    chk("mrst.addr1", imem_addr, 32'hBFC0_0004);
    step(1, 0, 0, 0, 0, 1);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
